// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: lb/lh/lw/lbu/lhu/sb/sh/sw on an internal word RAM.
// Latency: LAT+2 cycles per legal access (accept, LAT busy cycles, done strobe).
// Backpressure: mem_stall holds the pipeline from acceptance through the last busy cycle.
module dmem_access_unit #(
  parameter int IDX_W = 10,  // word-index width; RAM depth = 2**IDX_W words
  parameter int LAT   = 2    // wait cycles per access, legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        MemRW,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mem_fault
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Captured request. Only the address bits that select a byte inside the
  // RAM are kept, which gives the modulo-RAM-size wrap for free.
  logic              req_store;
  logic [2:0]        req_f3;
  logic [IDX_W+1:0]  req_addr;
  logic [31:0]       req_wdata;

  logic              capture;
  logic              ram_we;
  logic              rdata_ld;
  logic              req_legal;

  logic [31:0]       ram [DEPTH];
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_off;
  logic [31:0]       ram_word;
  logic [31:0]       ram_merged;
  logic [31:0]       load_ext;

  // Address bits above the RAM range are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:IDX_W+2];

  // Legal funct3 per direction, plus natural alignment for half/word sizes.
  function automatic logic access_legal(input logic store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    if (store) begin
      f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    end
    case (f3[1:0])
      2'b01:   align_ok = (off[0] == 1'b0);
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok && align_ok;
  endfunction

  // Byte-lane merge: replicate the store data across lanes, then enable only
  // the lanes the size/offset select so untouched bytes keep their old value.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] res;
    case (f3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        lanes = {4{wd[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        lanes = {2{wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = wd;
      end
    endcase
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = lanes[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Select the addressed byte/half and sign- or zero-extend per funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{shifted[7]}},  shifted[7:0]};
      3'b100:  res = {24'h000000,        shifted[7:0]};
      3'b001:  res = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  res = {16'h0000,          shifted[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req_legal  = access_legal(MemRW, funct3, addr[1:0]);
  assign req_idx    = req_addr[IDX_W+1:2];
  assign req_off    = req_addr[1:0];
  assign ram_word   = ram[req_idx];
  assign ram_merged = store_merge(ram_word, req_wdata, req_f3, req_off);
  assign load_ext   = load_extend(ram_word, req_f3, req_off);

  // FSM next-state, counter and outputs; faults and stall are combinational.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mem_stall   = 1'b0;
    mem_fault   = 1'b0;
    rdata_valid = 1'b0;
    capture     = 1'b0;
    ram_we      = 1'b0;
    rdata_ld    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (req_legal) begin
            capture   = 1'b1;
            cnt_nxt   = 4'(LAT - 1);
            state_nxt = ST_BUSY;
            mem_stall = 1'b1;
          end else begin
            mem_fault = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        mem_stall = 1'b1;
        if (cnt == 4'd0) begin
          ram_we    = req_store;
          rdata_ld  = ~req_store;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        // Requests are never accepted here; the pipeline advances on this edge.
        rdata_valid = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; contents only matter while a request is in flight.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_store <= MemRW;
      req_f3    <= funct3;
      req_addr  <= addr[IDX_W+1:0];
      req_wdata <= wdata;
    end
  end

  // Load result register; stores and faults leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (rdata_ld) begin
      rdata <= load_ext;
    end
  end

  // RAM write port; reset on the commit edge abandons the store.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram[req_idx] <= ram_merged;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit against a byte-arithmetic memory model.
// Drives inputs and samples outputs on the falling clock edge.
// Each access is followed cycle by cycle: accept, LAT busy cycles, done strobe.
module tb_dmem_access_unit;

  localparam int IDX_W = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam int POOL  = 16;  // words used by random traffic (all pre-written)

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        MemRW;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_fault;

  always #5 clk = ~clk;

  dmem_access_unit #(.IDX_W(IDX_W), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .MemRW       (MemRW),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .mem_stall   (mem_stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_fault   (mem_fault)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit f3_ok;
    if (st) f3_ok = (f3 <= 3'd2);
    else    f3_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return f3_ok && ((a % size_of(f3)) == 0);
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = model_mem[word_idx(a)] >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = v % 65536;
      default: v = model_mem[word_idx(a)];
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          sz;
    int          sh;
    logic [31:0] mask;
    sz = size_of(f3);
    sh = 8 * (a % 4);
    if (sz == 4) mask = 32'hFFFF_FFFF;
    else         mask = ((32'd1 << (8 * sz)) - 32'd1) << sh;
    model_mem[word_idx(a)] = (model_mem[word_idx(a)] & ~mask) | ((wd << sh) & mask);
  endtask

  function automatic logic [31:0] pool_addr();
    logic [31:0] a;
    a = {20'($urandom), 6'd0, 6'($urandom_range(0, 4 * POOL - 1))};
    return a;
  endfunction

  task automatic drive_garbage(input bit vld);
    mem_valid = vld;
    MemRW     = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = pool_addr();
    wdata     = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_valid = 1'b0;
    drive_garbage(1'b0);
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_vld",   32'(rdata_valid), 32'd0);
  endtask

  // One request, followed through to its done cycle. hold keeps mem_valid
  // asserted with random other traffic while the unit is busy and done.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    bit ok;
    ok = model_legal(st, f3, a);
    @(negedge clk);
    mem_valid = 1'b1;
    MemRW     = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    if (!ok) begin
      chk("fault",       32'(mem_fault), 32'd1);
      chk("fault_stall", 32'(mem_stall), 32'd0);
      chk("fault_vld",   32'(rdata_valid), 32'd0);
      chk("fault_rdata", rdata, exp_rdata);
      return;
    end
    chk("acc_stall", 32'(mem_stall), 32'd1);
    chk("acc_fault", 32'(mem_fault), 32'd0);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      drive_garbage(hold);
      #1;
      chk("busy_stall", 32'(mem_stall), 32'd1);
      chk("busy_vld",   32'(rdata_valid), 32'd0);
      chk("busy_fault", 32'(mem_fault), 32'd0);
      chk("busy_rdata", rdata, exp_rdata);
    end
    @(negedge clk);
    drive_garbage(hold);
    #1;
    if (st) model_store(f3, a, wd);
    else    exp_rdata = model_load(f3, a);
    chk("done_stall", 32'(mem_stall), 32'd0);
    chk("done_vld",   32'(rdata_valid), 32'd1);
    chk("done_fault", 32'(mem_fault), 32'd0);
    chk("done_rdata", rdata, exp_rdata);
    if (hold) idle_cycle();
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    rst       = 1'b1;
    mem_valid = 1'b0;
    MemRW     = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_vld",   32'(rdata_valid), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    rst = 1'b0;

    // Give every pool word a known value before anything reads it.
    for (int i = 0; i < POOL; i++) access(1'b1, 3'd2, 32'(4 * i), $urandom, 1'b0);

    // Word store/load round trip.
    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    chk("t1_lw", rdata, 32'hDEADBEEF);

    // Byte store into an existing word, then word/signed/unsigned reads.
    access(1'b1, 3'd2, 32'h14, 32'h11223344, 1'b0);
    access(1'b1, 3'd0, 32'h17, 32'h000000AB, 1'b0);
    access(1'b0, 3'd2, 32'h14, 32'h0, 1'b0);
    chk("t2_lw", rdata, 32'hAB223344);
    access(1'b0, 3'd0, 32'h17, 32'h0, 1'b0);
    chk("t2_lb", rdata, 32'hFFFFFFAB);
    access(1'b0, 3'd4, 32'h17, 32'h0, 1'b0);
    chk("t2_lbu", rdata, 32'h000000AB);

    // Upper-half store, then word/signed/unsigned reads.
    access(1'b1, 3'd2, 32'h18, 32'h0, 1'b0);
    access(1'b1, 3'd1, 32'h1A, 32'h00008001, 1'b0);
    access(1'b0, 3'd2, 32'h18, 32'h0, 1'b0);
    chk("t3_lw", rdata, 32'h80010000);
    access(1'b0, 3'd1, 32'h1A, 32'h0, 1'b0);
    chk("t3_lh", rdata, 32'hFFFF8001);
    access(1'b0, 3'd5, 32'h1A, 32'h0, 1'b0);
    chk("t3_lhu", rdata, 32'h00008001);

    // Misaligned and illegal-funct3 requests, issued back to back.
    access(1'b0, 3'd2, 32'h0102, 32'h0, 1'b0);
    access(1'b0, 3'd1, 32'h0103, 32'h0, 1'b0);
    access(1'b0, 3'd3, 32'h0010, 32'h0, 1'b0);
    idle_cycle();
    chk("t4_rdata_kept", rdata, 32'h00008001);

    // Reset in the second busy cycle abandons the store.
    access(1'b1, 3'd2, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    mem_valid = 1'b1; MemRW = 1'b1; funct3 = 3'd2; addr = 32'h20; wdata = 32'h12345678;
    #1;
    chk("t5_acc_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_rdata = 32'd0;
    chk("t5_stall", 32'(mem_stall), 32'd0);
    chk("t5_vld",   32'(rdata_valid), 32'd0);
    chk("t5_rdata", rdata, 32'd0);
    access(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    chk("t5_lw", rdata, 32'h00000000);

    // Aliased address with mem_valid held through busy and done.
    access(1'b1, 3'd2, 32'(4 * DEPTH), 32'hCAFEF00D, 1'b1);
    access(1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    chk("t6_lw", rdata, 32'hCAFEF00D);

    // Random traffic over the pre-written pool.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      a = pool_addr();
      if ($urandom_range(0, 4) != 0) a = a - (a % size_of(f3));
      access(st, f3, a, $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Read back the whole pool.
    for (int i = 0; i < POOL; i++) access(1'b0, 3'd2, 32'(4 * i), 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
